// File: rtl/seg_pkg.sv
// seg_pkg: segment bit order, scan-slot state type and the hex font shared by the scan controller.
package seg_pkg;
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;
  typedef enum logic {ST_BLANK, ST_SHOW} scan_state_e;
  // {a..g} per hex value, entry 0 in the low bits
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to {a..g} segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_FONT[hex_i];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan with dead-time blanking, blink and PWM brightness.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   seg_en,
  output logic [7:0]              seg_out0,
  output logic [7:0]              seg_out1,
  output logic                    frame_tick
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [3:0] pwm_q, dig_snap_q, dig;
  logic blink_q, blink_d, dp_snap_q, blank_snap_q, blink_snap_q;
  logic dp_s, blank_s, blink_s, first, slot_end, frame_end, lit;
  logic [NUM_DIGITS-1:0] seg_en_q, seg_en_d;
  logic [7:0] seg_q, seg_d;
  logic frame_tick_q;
  logic [6:0] font;
  scan_state_e state;
  // On the first clock of a slot the live inputs stand in for the not-yet-loaded snapshot
  assign first   = cnt_q == '0;
  assign dig     = first ? digits[{slot_q, 2'b00} +: 4] : dig_snap_q;
  assign dp_s    = first ? dp[slot_q] : dp_snap_q;
  assign blank_s = first ? blank_mask[slot_q] : blank_snap_q;
  assign blink_s = first ? blink_mask[slot_q] : blink_snap_q;
  seg_hex_decode u_dec (.hex_i(dig), .seg_o(font));
  always_comb begin
    slot_end  = cnt_q == CW'(SCAN_DIV - 1);
    frame_end = slot_end && slot_q == SW'(NUM_DIGITS - 1);
    cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
    slot_d    = frame_end ? '0 : slot_end ? slot_q + SW'(1) : slot_q;
    frame_d   = !frame_end ? frame_q : frame_q == FW'(BLINK_FRAMES - 1) ? '0 : frame_q + FW'(1);
    blink_d   = blink_q ^ (frame_end && frame_q == FW'(BLINK_FRAMES - 1));
    state     = int'(cnt_q) < BLANK_CYCLES ? ST_BLANK : ST_SHOW;
    lit       = state == ST_SHOW && !blank_s && !(blink_s && blink_q) && pwm_q <= brightness;
    seg_en_d  = lit ? NUM_DIGITS'(1) << slot_q : '0;
    seg_d     = lit ? {font, dp_s} : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      slot_q       <= '0;
      frame_q      <= '0;
      pwm_q        <= '0;
      blink_q      <= 1'b0;
      dig_snap_q   <= '0;
      dp_snap_q    <= 1'b0;
      blank_snap_q <= 1'b0;
      blink_snap_q <= 1'b0;
      seg_en_q     <= '0;
      seg_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      frame_q      <= frame_d;
      pwm_q        <= pwm_q + 4'd1;
      blink_q      <= blink_d;
      dig_snap_q   <= dig;
      dp_snap_q    <= dp_s;
      blank_snap_q <= blank_s;
      blink_snap_q <= blink_s;
      seg_en_q     <= seg_en_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_end;
    end
  end
  assign seg_en     = seg_en_q;
  assign seg_out0   = seg_q;
  assign seg_out1   = seg_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, blanking, masks, blink, PWM, snapshot and async reset.
module tb_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 20;
  localparam int BC = 4;
  localparam int BF = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] digits;
  logic [3:0] dp, blank_mask, blink_mask, brightness, seg_en;
  logic [7:0] seg_out0, seg_out1;
  logic frame_tick;
  logic [15:0] model_digits;
  logic [6:0] font [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  int checks = 0, errors = 0, k = 0, ft_cnt = 0;
  int lit_cnt [4];
  int e3 [4] = '{0, 16, 16, 0};

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .brightness(brightness), .seg_en(seg_en),
    .seg_out0(seg_out0), .seg_out1(seg_out1), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic clear_counts();
    foreach (lit_cnt[i]) lit_cnt[i] = 0;
    ft_cnt = 0;
  endtask

  // After edge k the outputs reflect scan position k-1 counted from reset release
  task automatic tick_check();
    int c, s, p, ph;
    logic lit;
    logic [3:0] een;
    logic [7:0] eseg;
    @(posedge clk);
    k++;
    @(negedge clk);
    c = (k - 1) % SD;
    s = ((k - 1) / SD) % ND;
    p = (k - 1) % 16;
    ph = ((k - 1) / (SD * ND) / BF) % 2;
    lit = c >= BC && !blank_mask[s] && !(blink_mask[s] && ph == 1) && p <= int'(brightness);
    een = lit ? 4'(1 << s) : 4'b0;
    eseg = lit ? {font[model_digits[s*4 +: 4]], dp[s]} : 8'h00;
    chk("seg_en", seg_en, een);
    chk("seg_out0", seg_out0, eseg);
    chk("seg_out1", seg_out1, eseg);
    chk("frame_tick", frame_tick, k % (SD * ND) == 0);
    chk("onehot0", $onehot0(seg_en), 1);
    for (int i = 0; i < 4; i++) if (seg_en[i]) lit_cnt[i]++;
    if (frame_tick) ft_cnt++;
  endtask

  initial begin
    digits = 16'h3210;
    model_digits = 16'h3210;
    dp = '0;
    blank_mask = '0;
    blink_mask = '0;
    brightness = 4'd15;
    repeat (2) @(negedge clk);
    chk("rst_seg_en", seg_en, 0);
    chk("rst_seg_out0", seg_out0, 0);
    chk("rst_seg_out1", seg_out1, 0);
    chk("rst_frame_tick", frame_tick, 0);
    rst_n = 1'b1;
    clear_counts();
    repeat (5) tick_check();
    chk("t1_first_en", seg_en, 4'b0001);
    chk("t1_digit0", seg_out0, 8'b11111100);
    repeat (155) tick_check();
    for (int i = 0; i < 4; i++) chk("t1_lit_count", lit_cnt[i], 32);
    chk("t1_frame_ticks", ft_cnt, 2);
    blank_mask = 4'b0100;
    dp = 4'b0001;
    clear_counts();
    repeat (5) tick_check();
    chk("t2_dp_digit0", seg_out0, 8'b11111101);
    repeat (75) tick_check();
    chk("t2_blanked", lit_cnt[2], 0);
    chk("t2_digit0_count", lit_cnt[0], 16);
    blank_mask = '0;
    dp = '0;
    blink_mask = 4'b0010;
    for (int f = 0; f < 4; f++) begin
      clear_counts();
      repeat (80) tick_check();
      chk("t3_blink_digit1", lit_cnt[1], e3[f]);
      chk("t3_digit0", lit_cnt[0], 16);
    end
    blink_mask = '0;
    brightness = 4'd0;
    clear_counts();
    repeat (80) tick_check();
    chk("t4_br0_total", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 4);
    brightness = 4'd7;
    clear_counts();
    repeat (80) tick_check();
    chk("t4_br7_total", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 32);
    brightness = 4'd15;
    repeat (30) tick_check();
    digits = 16'hFFFF;
    repeat (5) tick_check();
    chk("t5_hold_en", seg_en, 4'b0010);
    chk("t5_hold_seg", seg_out0, 8'b01100000);
    repeat (5) tick_check();
    model_digits = 16'hFFFF;
    repeat (5) tick_check();
    chk("t5_new_en", seg_en, 4'b0100);
    chk("t5_new_seg", seg_out0, 8'b10001110);
    repeat (5) tick_check();
    chk("t6_pre_en", seg_en, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_en", seg_en, 0);
    chk("t6_async_out0", seg_out0, 0);
    chk("t6_async_out1", seg_out1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (4) tick_check();
    tick_check();
    chk("t6_first_en", seg_en, 4'b0001);
    chk("t6_first_seg", seg_out0, 8'b10001110);
    repeat (75) tick_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
